// File: rtl/ws_pkg.sv
// ws_pkg: shared constants, FSM states and size helpers for the binary-conv window datapath.
package ws_pkg;

    localparam int IMAGE_ROW_LEN = 200;
    localparam int IMAGE_COL_LEN = 60;
    localparam int STRIDE        = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WIN,
        S_ACCUM,
        S_OUTPUT,
        S_SLIDE,
        S_DONE
    } state_t;

    function automatic int win_bits(input int k);
        return k * k;
    endfunction

    function automatic int cnt_w(input int k);
        return $clog2(k * k + 1);
    endfunction

endpackage

// File: rtl/chunk_popcount.sv
// chunk_popcount: combinational popcount of the bitwise XNOR of two CHUNK-bit vectors.
module chunk_popcount #(
    parameter int CHUNK = 32,
    localparam int PC_W = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic [PC_W-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < CHUNK; i++) count_o = count_o + PC_W'(a_i[i] ~^ b_i[i]);
    end

endmodule

// File: rtl/window_xnor_popcount.sv
// window_xnor_popcount: XNOR-popcount of each binary window against a stored kernel,
// thresholded to one activation bit per window and returned over valid/ready.
module window_xnor_popcount
    import ws_pkg::*;
#(
    parameter int KERNEL_SIZE = 16,
    parameter int CHUNK       = 32,
    parameter int NUM_WINDOWS = 8325,
    localparam int WIN_BITS   = win_bits(KERNEL_SIZE),
    localparam int CNT_W      = cnt_w(KERNEL_SIZE),
    localparam int NSLICE     = WIN_BITS / CHUNK,
    localparam int WADDR_W    = NSLICE > 1 ? $clog2(NSLICE) : 1,
    localparam int IDX_W      = NUM_WINDOWS > 1 ? $clog2(NUM_WINDOWS) : 1,
    localparam int PC_W       = $clog2(CHUNK + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WIN_BITS-1:0] win_in,
    input  logic                win_valid,
    output logic                ws_slide,
    input  logic                w_wen,
    input  logic [WADDR_W-1:0]  w_addr,
    input  logic [CHUNK-1:0]    w_data,
    input  logic [CNT_W-1:0]    thresh,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_bit,
    output logic [CNT_W-1:0]    out_count,
    output logic [IDX_W-1:0]    out_idx,
    output logic                busy,
    output logic                done
);

    state_t              state_q;
    logic [CHUNK-1:0]    w_q [NSLICE];
    logic [WIN_BITS-1:0] win_q;
    logic [CNT_W-1:0]    thresh_q, acc_q, acc_d, out_count_q;
    logic [WADDR_W-1:0]  slice_q;
    logic [IDX_W-1:0]    win_cnt_q;
    logic                out_valid_q, out_bit_q, ws_slide_q, busy_q, done_q;
    logic [PC_W-1:0]     pc;
    logic                last_slice, last_win;

    // The capture register shifts down one slice per cycle, so the active slice is always its LSBs.
    chunk_popcount #(.CHUNK(CHUNK)) u_pc (
        .a_i    (win_q[CHUNK-1:0]),
        .b_i    (w_q[slice_q]),
        .count_o(pc)
    );

    assign acc_d      = acc_q + CNT_W'(pc);
    assign last_slice = slice_q == WADDR_W'(NSLICE - 1);
    assign last_win   = win_cnt_q == IDX_W'(NUM_WINDOWS - 1);

    // Weight RAM keeps its contents across reset.
    always_ff @(posedge clk)
        if (w_wen && state_q == S_IDLE) w_q[w_addr] <= w_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            thresh_q    <= '0;
            win_q       <= '0;
            acc_q       <= '0;
            slice_q     <= '0;
            win_cnt_q   <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            ws_slide_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ws_slide_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    thresh_q  <= thresh;
                    busy_q    <= 1'b1;
                    win_cnt_q <= '0;
                    state_q   <= S_WAIT_WIN;
                end
                S_WAIT_WIN: if (win_valid) begin
                    win_q   <= win_in;
                    acc_q   <= '0;
                    slice_q <= '0;
                    state_q <= S_ACCUM;
                end
                S_ACCUM: begin
                    acc_q   <= acc_d;
                    win_q   <= win_q >> CHUNK;
                    slice_q <= slice_q + 1'b1;
                    if (last_slice) begin
                        out_valid_q <= 1'b1;
                        out_count_q <= acc_d;
                        out_bit_q   <= acc_d >= thresh_q;
                        state_q     <= S_OUTPUT;
                    end
                end
                S_OUTPUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    if (last_win) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        win_cnt_q  <= win_cnt_q + 1'b1;
                        ws_slide_q <= 1'b1;
                        state_q    <= S_SLIDE;
                    end
                end
                S_SLIDE: state_q <= S_WAIT_WIN;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_count = out_count_q;
    assign out_idx   = win_cnt_q;
    assign ws_slide  = ws_slide_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
